// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel counters, delayed sync/blanking aligned to the
// frame-buffer latency, line/frame strobes and a free-running frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int PIPE_DELAY  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic       colour,
  output logic [9:0] counter_H,
  output logic [9:0] counter_V,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       pixel_out,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // With no tick delay the delay line collapses to one register clocked every cycle.
  localparam int DEPTH   = (PIPE_DELAY == 0) ? 1 : PIPE_DELAY;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counters");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..7");
  end

  logic h_last;
  logic v_last;
  assign h_last = (counter_H == H_LAST);
  assign v_last = (counter_V == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_H   <= '0;
      counter_V   <= '0;
      frame_count <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pixel_tick) begin
        if (h_last) begin
          counter_H  <= '0;
          line_start <= 1'b1;
          if (v_last) begin
            counter_V   <= '0;
            frame_start <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end else begin
            counter_V <= counter_V + 10'd1;
          end
        end else begin
          counter_H <= counter_H + 10'd1;
        end
      end
    end
  end

  logic       hs_raw;
  logic       vs_raw;
  logic       de_raw;
  logic [2:0] raw_bus;
  assign hs_raw  = (counter_H >= HS_BEGIN) && (counter_H <= HS_END);
  assign vs_raw  = (counter_V >= VS_BEGIN) && (counter_V <= VS_END);
  assign de_raw  = (counter_H < H_VIS) && (counter_V < V_VIS);
  assign raw_bus = {hs_raw, vs_raw, de_raw};

  // Each stage is a {hs, vs, de} triplet; the top triplet drives the outputs.
  logic [3*DEPTH-1:0] pipe_q;
  logic [3*DEPTH-1:0] pipe_d;
  logic               shift_en;
  logic               de_load;

  if (DEPTH == 1) begin : g_single
    assign pipe_d = raw_bus;
  end else begin : g_multi
    assign pipe_d = {pipe_q[3*DEPTH-4:0], raw_bus};
  end

  assign shift_en = (PIPE_DELAY == 0) | pixel_tick;
  // pixel_out uses the de value entering the top stage so it stays aligned with display_on.
  assign de_load  = pipe_d[3*DEPTH-3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q    <= '0;
      pixel_out <= 1'b0;
    end else if (shift_en) begin
      pipe_q    <= pipe_d;
      pixel_out <= colour & de_load;
    end
  end

  assign hsync      = pipe_q[3*DEPTH-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync      = pipe_q[3*DEPTH-2] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign display_on = pipe_q[3*DEPTH-3];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen on a reduced 12x8 raster so full
// frames and the frame-count wrap fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 6, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;  // 12
  localparam int VT = VA + VF + VS + VB;  // 8
  localparam int FT = HT * VT;            // 96

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_tick = 1'b0;
  logic       colour = 1'b0;
  logic [9:0] counter_H, counter_V;
  logic       hsync, vsync, display_on, pixel_out, line_start, frame_start;
  logic [7:0] frame_count;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1'b0), .PIPE_DELAY(PD)
  ) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .colour(colour),
    .counter_H(counter_H), .counter_V(counter_V), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .pixel_out(pixel_out), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [33:0] sb_q[$];

  int n = 0;          // ticks since reset release
  bit last_col = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit hs_at(input int m);
    int hm = m % HT;
    return (hm >= HA + HF) && (hm < HA + HF + HS);
  endfunction

  function automatic bit vs_at(input int m);
    int vm = (m / HT) % VT;
    return (vm >= VA + VF) && (vm < VA + VF + VS);
  endfunction

  function automatic bit de_at(input int m);
    return ((m % HT) < HA) && (((m / HT) % VT) < VA);
  endfunction

  // Expected output record after n ticks; delayed terms come from position n-PD.
  function automatic logic [33:0] model(input int cnt, input bit ticked, input bit lc);
    bit hsd, vsd, ded, px, ls, fs;
    logic [9:0] h, v;
    logic [7:0] fc;
    h   = 10'(cnt % HT);
    v   = 10'((cnt / HT) % VT);
    fc  = 8'((cnt / FT) % 256);
    hsd = (cnt >= PD) && hs_at(cnt - PD);
    vsd = (cnt >= PD) && vs_at(cnt - PD);
    ded = (cnt >= PD) && de_at(cnt - PD);
    px  = lc && ded;
    ls  = ticked && (cnt > 0) && (h == 10'd0);
    fs  = ticked && (cnt > 0) && (cnt % FT == 0);
    return {h, v, ~hsd, ~vsd, ded, px, ls, fs, fc};
  endfunction

  function automatic logic [33:0] dut_rec();
    return {counter_H, counter_V, hsync, vsync, display_on, pixel_out,
            line_start, frame_start, frame_count};
  endfunction

  localparam logic [33:0] RESET_REC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

  // Drive one clock of stimulus and queue the response it should produce.
  task automatic step(input bit t, input bit c);
    bit ticked;
    pixel_tick = t;
    colour     = c;
    @(posedge clk);
    #1;
    ticked = 1'b0;
    if (reset) begin
      n = 0;
      last_col = 1'b0;
    end else if (t) begin
      n++;
      last_col = c;
      ticked = 1'b1;
    end
    sb_q.push_back(model(n, ticked, last_col));
  endtask

  // Monitor: the DUT presents a full output record every clock.
  initial begin
    logic [33:0] req;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        req = sb_q.pop_front();
        check("scoreboard", 64'(dut_rec()), 64'(req));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs_low, vs_low, px_ones, de_ones, ls_cnt, fs_cnt;
    int first_hs_h;
    logic [19:0] first_vs;
    int drain;

    #1;
    check("reset_state", 64'(dut_rec()), 64'(RESET_REC));
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    reset = 1'b0;

    // Two frames, colour white; measure the second frame against hand counts.
    hs_low = 0; vs_low = 0; px_ones = 0; de_ones = 0; ls_cnt = 0; fs_cnt = 0;
    first_hs_h = -1; first_vs = '1;
    for (int i = 1; i <= 2 * FT; i++) begin
      step(1'b1, 1'b1);
      if (first_hs_h < 0 && hsync == 1'b0) first_hs_h = int'(counter_H);
      if (first_vs == '1 && vsync == 1'b0) first_vs = {counter_V, counter_H};
      if (i > FT) begin
        hs_low  += int'(!hsync);
        vs_low  += int'(!vsync);
        px_ones += int'(pixel_out);
        de_ones += int'(display_on);
        ls_cnt  += int'(line_start);
        fs_cnt  += int'(frame_start);
      end
    end
    check("hsync_first_low_h", 64'(first_hs_h), 64'd10);
    check("vsync_first_low_vh", 64'(first_vs), {44'd0, 10'd5, 10'd2});
    check("hsync_low_per_frame", 64'(hs_low), 64'd16);
    check("vsync_low_per_frame", 64'(vs_low), 64'd12);
    check("pixel_ones_per_frame", 64'(px_ones), 64'd24);
    check("display_on_per_frame", 64'(de_ones), 64'd24);
    check("line_starts_per_frame", 64'(ls_cnt), 64'd8);
    check("frame_starts_per_frame", 64'(fs_cnt), 64'd1);
    check("frame_count_after_2", 64'(frame_count), 64'd2);

    // One tick in four, random colour: strobes must stay one clock wide.
    ls_cnt = 0;
    for (int i = 0; i < 4 * FT; i++) begin
      step(i % 4 == 0, 1'($urandom_range(0, 1)));
      ls_cnt += int'(line_start);
    end
    check("line_starts_slow_tick", 64'(ls_cnt), 64'd8);

    // Park at (7,3) mid-frame, then reset asynchronously between edges.
    while (n % FT != 3 * HT + 7) step(1'b1, 1'($urandom_range(0, 1)));
    check("pre_reset_position", {44'd0, counter_V, counter_H}, {44'd0, 10'd3, 10'd7});
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check("async_reset_state", 64'(dut_rec()), 64'(RESET_REC));
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    reset = 1'b0;

    // Long run: frame counter through 255 and back to 0.
    fs_cnt = 0;
    for (int i = 1; i <= 256 * FT; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      fs_cnt += int'(frame_start);
      if (i == 255 * FT) check("frame_count_255", 64'(frame_count), 64'd255);
    end
    check("frame_count_wrap", 64'(frame_count), 64'd0);
    check("frame_starts_256", 64'(fs_cnt), 64'd256);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the display path. Generates the pixel counters `counter_H` and `counter_V` that drive the frame buffer / sprite lookup stage.
- Takes that stage's 1-bit `colour` back in. Emits `hsync`, `vsync` and the blanked pixel bit, each delayed by a parameterised number of pixel ticks so sync matches the frame-buffer path latency.
- Also provides frame/line strobes and a frame counter for game-logic pacing.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
- PIPE_DELAY, 2, pixel-tick delay applied to sync/display outputs; legal range 0..7

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pixel_tick  input  1  pixel-rate enable; all counters and the delay line advance only when high
- colour  input  1  pixel value from frame buffer stage (1 = white)
- counter_H  output  10  current horizontal pixel position, 0..H_TOTAL-1
- counter_V  output  10  current vertical line position, 0..V_TOTAL-1
- hsync  output  1  delayed horizontal sync
- vsync  output  1  delayed vertical sync
- display_on  output  1  delayed active-video flag
- pixel_out  output  1  colour AND display_on, registered
- line_start  output  1  one-clk pulse when counter_H wraps to 0
- frame_start  output  1  one-clk pulse when (counter_H, counter_V) becomes (0,0)
- frame_count  output  8  completed frames, modulo 256

Behaviour:
- Reset (async assert, sync-safe deassert):
  - counter_H = 0, counter_V = 0, frame_count = 0.
  - hsync = vsync = ~SYNC_ACTIVE, display_on = 0, pixel_out = 0, strobes = 0.
  - Every delay-line stage is loaded with the inactive values.
- Horizontal counter: on clk edge with pixel_tick = 1, counter_H increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: increments only on an H wrap; at V_TOTAL-1 with an H wrap, counter_V wraps to 0 and frame_count increments (255 wraps to 0).
- pixel_tick = 0: every register holds, except line_start and frame_start, which are 0 (they are single clk cycles wide, not tick wide).
- Undelayed combinational terms, from the current counters:
  - hs_raw is asserted when H_ACTIVE+H_FP <= counter_H <= H_ACTIVE+H_FP+H_SYNC-1.
  - vs_raw uses the same rule on counter_V with the V parameters.
  - de_raw = (counter_H < H_ACTIVE) && (counter_V < V_ACTIVE).
- Delay line: a shift register of PIPE_DELAY stages holding {hs, vs, de}, advancing on pixel_tick.
  - Outputs are stage PIPE_DELAY's contents, so a counter value's sync/de appears exactly PIPE_DELAY ticks later.
  - PIPE_DELAY = 0: outputs are hs_raw/vs_raw/de_raw registered once, i.e. 1 clk, with no tick delay.
- hsync/vsync drive SYNC_ACTIVE when their delayed raw term is 1, else ~SYNC_ACTIVE.
- pixel_out: registered on pixel_tick as colour & delayed de.
  - Forced 0 whenever delayed de = 0, regardless of colour, so the blanking interval is always black.
- line_start / frame_start are registered.
  - They assert in the same clk cycle the counters first show H = 0 (resp. H = 0, V = 0).
  - Not asserted on the first tick after reset; the initial (0,0) after reset is not a frame start.
- Reset mid-frame: counters return to 0 immediately and the delay line is flushed.
  - The first frame after reset is treated as a full frame; frame_count increments only on the first wrap.
- Counter widths: 10 bits. H_TOTAL and V_TOTAL must be ≤ 1024; larger values are a configuration error.

Test Plan:
- Reset, then 800 ticks -> counter_H runs 0..799, back to 0; counter_V = 1; line_start high exactly 1 clk when counter_H shows 0.
- Default params, PIPE_DELAY = 2 -> hsync low for exactly 96 ticks, first low 2 ticks after counter_H = 656; high otherwise.
- Full frame of 800*525 = 420000 ticks -> frame_start one pulse, frame_count = 1; vsync low for 1600 ticks beginning 2 ticks after counter_V = 490, H = 0.
- colour held at 1 -> pixel_out = 1 only while delayed display_on = 1 (640 ticks per active line, 480 lines); 0 in all blanking regions.
- pixel_tick high 1 in 4 clks -> counters/syncs advance per tick only; strobes 1 clk wide; tick rate has no effect on the totals.
- Assert reset at counter_H = 300, counter_V = 200 -> all outputs immediately at reset values; after release, counting restarts at (0,0) with no spurious frame_start.
